multi_pulser: RTL and testbench
===============================

# multi_pulser

Multi-channel, parametrised one-pulser. Each channel synchronises an asynchronous button or switch input, debounces it, and emits a single-cycle pulse on a selected edge of the debounced level. It supersedes the single-channel one-pulser in front of counters and control FSMs, and lets one instance serve a whole button bank.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent input channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, default 4: consecutive differing samples required to accept a level change (≥1).
- `EDGE_MODE`, default 0: pulse condition. 0 = rising, 1 = falling, 2 = both edges.
- `REPEAT_DELAY`, default 50: cycles from a press pulse to the first repeat pulse (≥1). Used only with `MULTI_PULSER_REPEAT_EN`.
- `REPEAT_PERIOD`, default 10: cycles between subsequent repeat pulses (≥1). Used only with `MULTI_PULSER_REPEAT_EN`.

Ports:
- `clk` input, 1 bit: single clock. All flops are rising-edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `btnIn` input, `CHANNELS` bits: raw asynchronous inputs, active-high (1 = pressed).
- `pulser` output, `CHANNELS` bits: registered one-cycle pulses, one bit per channel.
- `level` output, `CHANNELS` bits: registered debounced level per channel.

## Operation
- Channels are fully independent. Any subset may pulse in the same cycle.
- Synchroniser: a `SYNC_STAGES`-deep shift register per channel. Its last stage is `s`.
- Debounce, per channel. State is `level` plus counter `cnt`, which is `$clog2(DEBOUNCE_CYCLES+1)` bits wide. On each edge:
  - If `s == level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level <= s`, `cnt <= 0`. This is the accept event.
  - Else: `cnt <= cnt+1`.
- Pulse generation: `pulser[i] <= 1` on the edge of an accept event whose direction matches `EDGE_MODE`. Otherwise `pulser[i] <= 0`. Every pulse is exactly one cycle wide.
- Glitches: a glitch shorter than `DEBOUNCE_CYCLES` synchronised samples produces no pulse and resets `cnt`.
- `DEBOUNCE_CYCLES == 1`: no filtering. Every change of `s` is accepted on the next edge.
- Reset (`rst == 0` at an edge) clears all synchroniser flops, `level`, `cnt`, `pulser`, and the repeat state to 0.
  - Reset mid-debounce discards the partial count.
  - An input held high across reset is seen as a fresh rising edge after reset. It pulses again in modes 0 and 2.

## Timing
- Reset values: `pulser` = 0 and `level` = 0 on all channels.
- Latency: let edge E be the first edge that samples the new `btnIn` value, held stable. Then `level` and `pulser` change at edge E+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1. They are visible in the following cycle.
  - Defaults: the output updates at the 6th edge, counting E as the 1st.
- Minimum spacing between two accepted edges on one channel is `DEBOUNCE_CYCLES` cycles.
- There is no handshake. `pulser` is fire-and-forget and must be consumed in the cycle it is high.

## Configuration
- `MULTI_PULSER_REPEAT_EN` defined: auto-repeat is enabled (typematic behaviour).
  - A per-channel repeat counter, wide enough for `max(REPEAT_DELAY, REPEAT_PERIOD)`, runs while `level == 1`. It clears when `level == 0`.
  - After the press pulse, the first repeat pulse occurs `REPEAT_DELAY` cycles later. Further repeats occur every `REPEAT_PERIOD` cycles while `level` stays 1.
  - Repeats are generated only in `EDGE_MODE` 0 and 2.
  - Release stops repeats immediately. In mode 2 the release emits its normal falling pulse.
  - A repeat pulse and an edge pulse never coincide. The repeat counter restarts on the press accept event.
- `MULTI_PULSER_REPEAT_EN` undefined: no repeat logic is synthesised. Each press yields exactly one pulse, and `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
- Reset and basic press, defaults: hold `rst = 0` for 2 cycles, then release it. Drive `btnIn[0]` high at edge E and hold.
  - Required: `pulser[0]` is high for exactly one cycle after edge E+5.
  - Required: `level[0] = 1` from then on.
  - Required: all other bits stay 0.
- Glitch rejection: pulse `btnIn[1]` high for 3 cycles with `DEBOUNCE_CYCLES = 4`.
  - Required: `pulser[1]` and `level[1]` stay 0.
  - Then hold it high for 4 cycles. Required: one pulse.
- Edge modes: the same 20-cycle high pulse is applied in three runs.
  - `EDGE_MODE = 0`: one pulse on press.
  - `EDGE_MODE = 1`: one pulse on release.
  - `EDGE_MODE = 2`: two pulses, separated by 20 cycles.
- Simultaneous channels: drive `btnIn = 4'b1111` in one cycle.
  - Required: `pulser = 4'b1111` for the same single cycle.
- Reset mid-operation: assert `rst = 0` while `cnt = 2` on channel 0 with `btnIn[0]` held high, then release reset.
  - Required: no pulse during reset.
  - Required: one pulse 6 edges after the first post-reset edge.
- Auto-repeat, with `MULTI_PULSER_REPEAT_EN`, `REPEAT_DELAY = 50`, `REPEAT_PERIOD = 10`: hold `btnIn[2]` high for 100 cycles after the press pulse.
  - Required: the press pulse, then pulses at +50, +60, +70, +80, +90 and +100 cycles.
  - Required: no pulses after release.
  - Without the macro, the same stimulus gives exactly 1 pulse.

Source files
------------

// File: rtl/multi_pulser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_pulser
// Description : Multi-channel one-pulser. Each channel synchronises a raw
//               button input, debounces it and emits a one-cycle pulse on
//               the selected edge of the debounced level. Optional
//               typematic auto-repeat is built when MULTI_PULSER_REPEAT_EN
//               is defined; without it no repeat logic exists.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pulser #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btnIn,
  output logic [CHANNELS-1:0] pulser,
  output logic [CHANNELS-1:0] level
);

  // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int              c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Which accepted directions produce a pulse.
  localparam logic c_PULSE_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
  localparam logic c_PULSE_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

`ifdef MULTI_PULSER_REPEAT_EN
  // Repeat counter must hold the larger of the two repeat intervals.
  localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
  localparam logic [c_RPT_W-1:0] c_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);
`else
  // Repeat timing has no meaning without auto-repeat; nothing is built.
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_params_ignored
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   w_accept;
    logic                   w_edge_pulse;
    logic                   w_rpt_pulse;

    // Synchroniser shift register; the oldest stage feeds the debouncer.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], btnIn[i]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Level change is accepted once the synchronised input has differed
    // from the current level for DEBOUNCE_CYCLES consecutive samples.
    assign w_accept = (w_s != r_level) && (r_cnt == c_CNT_LAST);

    assign w_edge_pulse = w_accept &&
                          ((w_s && c_PULSE_RISE) || (!w_s && c_PULSE_FALL));

    // Debounce state: any sample matching the level discards the run.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else if (w_s == r_level) begin
        r_cnt   <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end

`ifdef MULTI_PULSER_REPEAT_EN
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_rpt_armed;
    logic               w_rpt_hit;

    // Before the first repeat we wait the long delay, afterwards the period.
    assign w_rpt_hit = r_rpt_armed ? (r_rpt_cnt == c_PERIOD_LAST)
                                   : (r_rpt_cnt == c_DELAY_LAST);

    // An accept event always wins, so repeat and edge pulses never collide
    // and a release stops repeating on the very edge it is accepted.
    assign w_rpt_pulse = c_PULSE_RISE && r_level && !w_accept && w_rpt_hit;

    // Repeat timer runs only while held; a press accept restarts it.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_rpt_cnt   <= '0;
        r_rpt_armed <= 1'b0;
      end else if (w_accept || !r_level) begin
        r_rpt_cnt   <= '0;
        r_rpt_armed <= 1'b0;
      end else if (w_rpt_hit) begin
        r_rpt_cnt   <= '0;
        r_rpt_armed <= 1'b1;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      end
    end
`else
    assign w_rpt_pulse = 1'b0;
`endif

    // Output pulse register: high for exactly one cycle per event.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_edge_pulse || w_rpt_pulse;
      end
    end

    assign pulser[i] = r_pulse;
    assign level[i]  = r_level;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_pulser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multi_pulser
// Description : Self-checking bench for multi_pulser. Four instances share
//               the inputs: rising, falling and both-edge modes with default
//               timing, plus a 3-stage / no-filter instance. A sample-history
//               model predicts every output each cycle; directed checks pin
//               the model with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pulser;
  localparam int NI   = 4;
  localparam int NC   = 4;
  localparam int MAXE = 2048;
  localparam int RD   = 50;
  localparam int RP   = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] btn;
  logic [NC-1:0] pul [NI];
  logic [NC-1:0] lev [NI];

  always #5 clk = ~clk;

  multi_pulser #(.CHANNELS(NC), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut_m0 (.clk(clk), .rst(rst), .btnIn(btn), .pulser(pul[0]), .level(lev[0]));
  multi_pulser #(.CHANNELS(NC), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut_m1 (.clk(clk), .rst(rst), .btnIn(btn), .pulser(pul[1]), .level(lev[1]));
  multi_pulser #(.CHANNELS(NC), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut_m2 (.clk(clk), .rst(rst), .btnIn(btn), .pulser(pul[2]), .level(lev[2]));
  multi_pulser #(.CHANNELS(NC), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut_d1 (.clk(clk), .rst(rst), .btnIn(btn), .pulser(pul[3]), .level(lev[3]));

  function automatic int sync_of(int k); return (k == 3) ? 3 : 2; endfunction
  function automatic int deb_of(int k);  return (k == 3) ? 1 : 4; endfunction
  function automatic int mode_of(int k); return (k == 1) ? 1 : ((k == 2) ? 2 : 0); endfunction

  // Input history as seen at every rising edge.
  logic [NC-1:0] raw_hist [MAXE];
  bit            rst_hist [MAXE];
  int            n_edges = 0;

  always @(posedge clk) begin
    if (n_edges < MAXE) begin
      raw_hist[n_edges] <= btn;
      rst_hist[n_edges] <= rst;
    end
    n_edges <= n_edges + 1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Synchronised value the debouncer sees at edge m: the input sampled
  // 'sync' edges earlier, unless a reset edge flushed the pipeline since.
  function automatic bit s_before(int m, int c, int sync);
    int idx;
    idx = m - sync;
    if (idx < 0) return 1'b0;
    for (int j = idx; j < m; j++) if (!rst_hist[j]) return 1'b0;
    return raw_hist[idx][c];
  endfunction

  bit m_level [NI][NC];
  bit m_pulse [NI][NC];
  int m_press [NI][NC];
  int pcount  [NI][NC];
  int plast   [NI][NC];
  int pprev   [NI][NC];

  // Model rule: level flips when the last DEB synchronised samples (all
  // taken out of reset) disagree with it; repeats are timed from the press.
  function automatic void model_step(int k, int c, int e);
    bit all_diff;
    int d;
    m_pulse[k][c] = 1'b0;
    if (!rst_hist[e]) begin
      m_level[k][c] = 1'b0;
      m_press[k][c] = -1;
      return;
    end
    all_diff = 1'b1;
    for (int m = e - deb_of(k) + 1; m <= e; m++) begin
      if (m < 0) all_diff = 1'b0;
      else if (!rst_hist[m] || (s_before(m, c, sync_of(k)) == m_level[k][c])) all_diff = 1'b0;
    end
    if (all_diff) begin
      if (!m_level[k][c]) begin
        m_pulse[k][c] = (mode_of(k) != 1);
        m_level[k][c] = 1'b1;
        m_press[k][c] = e;
      end else begin
        m_pulse[k][c] = (mode_of(k) != 0);
        m_level[k][c] = 1'b0;
        m_press[k][c] = -1;
      end
    end
`ifdef MULTI_PULSER_REPEAT_EN
    else if (m_level[k][c] && (mode_of(k) != 1) && (m_press[k][c] >= 0)) begin
      d = e - m_press[k][c];
      if ((d == RD) || ((d > RD) && (((d - RD) % RP) == 0))) m_pulse[k][c] = 1'b1;
    end
`endif
  endfunction

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin : p_cmp
    int            e;
    logic [NC-1:0] ep;
    logic [NC-1:0] el;
    if ((n_edges > 0) && (n_edges <= MAXE)) begin
      e = n_edges - 1;
      for (int k = 0; k < NI; k++) begin
        for (int c = 0; c < NC; c++) begin
          model_step(k, c, e);
          ep[c] = m_pulse[k][c];
          el[c] = m_level[k][c];
          if (pul[k][c] === 1'b1) begin
            pcount[k][c]++;
            pprev[k][c] = plast[k][c];
            plast[k][c] = e;
          end
        end
        check($sformatf("model inst%0d pulser", k), pul[k], ep);
        check($sformatf("model inst%0d level", k), lev[k], el);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : p_stim
    int  base0, base1, base2;
    bit  found;
    rst = 1'b0;
    btn = '0;
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < NC; c++) begin
        pcount[k][c] = 0; plast[k][c] = 0; pprev[k][c] = 0; m_press[k][c] = -1;
      end
    steps(2);
    check("reset pulser m0", pul[0], 4'b0000);
    check("reset level m0", lev[0], 4'b0000);
    check("reset level d1", lev[3], 4'b0000);
    rst = 1'b1;
    steps(2);

    // Basic press: default instance pulses after E+5, no-filter one after E+3.
    btn[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("press m0 pulser", pul[0], (i == 6) ? 4'b0001 : 4'b0000);
      check("press d1 pulser", pul[3], (i == 4) ? 4'b0001 : 4'b0000);
    end
    check("press m0 level", lev[0], 4'b0001);

    // Glitch of 3 cycles is rejected, 4 cycles is accepted.
    btn[1] = 1'b1; steps(3); btn[1] = 1'b0; steps(12);
    check("glitch level", {31'd0, lev[0][1]}, 32'd0);
    check("glitch pulses", pcount[0][1], 32'd0);
    btn[1] = 1'b1; steps(4); btn[1] = 1'b0; steps(12);
    check("4-cycle pulses", pcount[0][1], 32'd1);
    btn = '0; steps(15);

    // Edge modes on a 20-cycle high pulse.
    base0 = pcount[0][3]; base1 = pcount[1][3]; base2 = pcount[2][3];
    btn[3] = 1'b1; steps(20); btn[3] = 1'b0; steps(15);
    check("mode0 pulses", pcount[0][3] - base0, 32'd1);
    check("mode1 pulses", pcount[1][3] - base1, 32'd1);
    check("mode2 pulses", pcount[2][3] - base2, 32'd2);
    check("mode2 spacing", plast[2][3] - pprev[2][3], 32'd20);

    // All channels together.
    btn = 4'b1111;
    steps(5);
    check("simul before", pul[0], 4'b0000);
    step();
    check("simul pulse", pul[0], 4'b1111);
    step();
    check("simul after", pul[0], 4'b0000);
    steps(8);
    btn = '0; steps(15);

    // Reset while channel 0 is mid-debounce (count of 2).
    btn[0] = 1'b1;
    steps(4);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pulse during reset", pul[0], 4'b0000);
    end
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("post-reset pulse", pul[0], (i == 6) ? 4'b0001 : 4'b0000);
    end
    btn = '0; steps(15);

    // Auto-repeat hold on channel 2.
    base0 = pcount[0][2];
    btn[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pul[0][2] === 1'b1) found = 1'b1;
    end
    check("repeat press seen", {31'd0, found}, 32'd1);
    steps(100);
    btn[2] = 1'b0;
    steps(30);
`ifdef MULTI_PULSER_REPEAT_EN
    check("repeat pulse count", pcount[0][2] - base0, 32'd7);
`else
    check("repeat pulse count", pcount[0][2] - base0, 32'd1);
`endif
    steps(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
